// File: rtl/life_pkg.sv
// Shared constants for the Game of Life generation sequencer:
// board geometry, FSM state encodings and halt reason codes.
package life_pkg;

  localparam int BOARD_DIM   = 16;
  localparam int BOARD_CELLS = BOARD_DIM * BOARD_DIM;

  // FSM state encodings (visible on the state output, so kept fixed)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_BUSY  = 3'd3;
  localparam logic [2:0] ST_LOAD  = 3'd4;
  localparam logic [2:0] ST_HALT  = 3'd5;

  // halt_reason codes
  localparam logic [1:0] HALT_NONE    = 2'd0;
  localparam logic [1:0] HALT_LIMIT   = 2'd1;
  localparam logic [1:0] HALT_EXTINCT = 2'd2;
  localparam logic [1:0] HALT_STABLE  = 2'd3;

endpackage

// File: rtl/life_period_timer.sv
// Loadable down-counter timing the gap between generations.
// A period of 0 is treated as 1; expire is high while the count sits at 1.
module life_period_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                clear,
  input  logic [PERIOD_W-1:0] period,
  output logic                expire
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;

  // next count: clear wins over load, otherwise count down to zero and stop
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = (period == '0) ? PERIOD_W'(1) : period;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - PERIOD_W'(1);
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == PERIOD_W'(1));

endmodule

// File: rtl/life_gen_sequencer.sv
// Generation sequencer for the 16x16 Life engine: run/pause/step/load
// control, generation period pacing, generation and population bookkeeping.
// Optional still-life halt is built when LIFE_STABLE_HALT_EN is defined.
//
//   state | meaning
//   IDLE  | stopped, waiting for a command
//   WAIT  | free running, counting down the generation period
//   ISSUE | one-cycle eng_step pulse
//   BUSY  | engine computing; pause/load are held as pending
//   LOAD  | board reload requested, waiting for load_ack
//   HALT  | stopped on limit / extinction / still life; only load exits
module life_gen_sequencer
  import life_pkg::*;
#(
  parameter int PERIOD_W = 24,
  parameter int GEN_W    = 32,
  parameter int POP_W    = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_run,
  input  logic                cmd_pause,
  input  logic                cmd_step,
  input  logic                cmd_load,
  input  logic [PERIOD_W-1:0] period,
  input  logic [GEN_W-1:0]    gen_limit,
  output logic                eng_step,
  input  logic                eng_done,
  input  logic [POP_W-1:0]    eng_birth,
  input  logic [POP_W-1:0]    eng_death,
  output logic                load_req,
  input  logic                load_ack,
  input  logic [POP_W-1:0]    load_pop,
  output logic [2:0]          state,
  output logic [GEN_W-1:0]    gen_cnt,
  output logic [POP_W-1:0]    population,
  output logic                halted,
  output logic [1:0]          halt_reason
);

  localparam int EXT_W = POP_W + 2;

  logic [2:0]       state_q, state_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic [POP_W-1:0] pop_q, pop_d;
  logic [1:0]       reason_q, reason_d;
  logic             single_q, single_d;
  logic             pend_pause_q, pend_pause_d;
  logic             pend_load_q, pend_load_d;
  logic             eng_step_q, load_req_q, halted_q;

  logic             timer_load, timer_clear, timer_expire;
  logic [GEN_W-1:0] gen_new;
  logic [EXT_W-1:0] pop_sum;
  logic [POP_W-1:0] pop_new;
  logic             limit_hit, stable;

  life_period_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .clear  (timer_clear),
    .period (period),
    .expire (timer_expire)
  );

  // Headroom of two bits lets the sum go above 256 or below zero before clamping.
  assign pop_sum   = {2'b00, pop_q} + {2'b00, eng_birth} - {2'b00, eng_death};
  assign gen_new   = (&gen_q) ? gen_q : gen_q + GEN_W'(1);
  assign limit_hit = (gen_limit != '0) && (gen_new == gen_limit);

`ifdef LIFE_STABLE_HALT_EN
  assign stable = (eng_birth == '0) && (eng_death == '0);
`else
  assign stable = 1'b0;
`endif

  // clamp the post-generation population to [0, BOARD_CELLS]
  always_comb begin
    pop_new = pop_sum[POP_W-1:0];
    if (pop_sum[EXT_W-1])                     pop_new = '0;
    else if (pop_sum > EXT_W'(BOARD_CELLS))   pop_new = POP_W'(BOARD_CELLS);
  end

  // FSM next state and bookkeeping updates
  always_comb begin
    state_d      = state_q;
    gen_d        = gen_q;
    pop_d        = pop_q;
    reason_d     = reason_q;
    single_d     = single_q;
    pend_pause_d = pend_pause_q;
    pend_load_d  = pend_load_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_load)       state_d = ST_LOAD;
        else if (cmd_pause) state_d = ST_IDLE;
        else if (cmd_step) begin
          state_d  = ST_ISSUE;
          single_d = 1'b1;
        end else if (cmd_run) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cmd_load)          state_d = ST_LOAD;
        else if (cmd_pause)    state_d = ST_IDLE;
        else if (timer_expire) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // the step is committed here, so pause/load already count as pending
        state_d      = ST_BUSY;
        pend_pause_d = pend_pause_q | cmd_pause;
        pend_load_d  = pend_load_q | cmd_load;
      end
      ST_BUSY: begin
        pend_pause_d = pend_pause_q | cmd_pause;
        pend_load_d  = pend_load_q | cmd_load;
        if (eng_done) begin
          gen_d = gen_new;
          pop_d = pop_new;
          if (limit_hit) begin
            state_d  = ST_HALT;
            reason_d = HALT_LIMIT;
          end else if (pop_new == '0) begin
            state_d  = ST_HALT;
            reason_d = HALT_EXTINCT;
          end else if (stable) begin
            state_d  = ST_HALT;
            reason_d = HALT_STABLE;
          end else if (pend_load_d) begin
            state_d = ST_LOAD;
          end else if (single_q || pend_pause_d) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
          single_d     = 1'b0;
          pend_pause_d = 1'b0;
          pend_load_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        if (load_ack) begin
          gen_d    = '0;
          pop_d    = load_pop;
          reason_d = HALT_NONE;
          state_d  = ST_IDLE;
        end
      end
      ST_HALT: begin
        if (cmd_load) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign timer_load  = (state_d == ST_WAIT) && (state_q != ST_WAIT);
  assign timer_clear = (state_q == ST_WAIT) && (state_d != ST_WAIT);

  // state, bookkeeping and registered control outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gen_q        <= '0;
      pop_q        <= '0;
      reason_q     <= HALT_NONE;
      single_q     <= 1'b0;
      pend_pause_q <= 1'b0;
      pend_load_q  <= 1'b0;
      eng_step_q   <= 1'b0;
      load_req_q   <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      gen_q        <= gen_d;
      pop_q        <= pop_d;
      reason_q     <= reason_d;
      single_q     <= single_d;
      pend_pause_q <= pend_pause_d;
      pend_load_q  <= pend_load_d;
      eng_step_q   <= (state_d == ST_ISSUE);
      load_req_q   <= (state_d == ST_LOAD);
      halted_q     <= (state_d == ST_HALT);
    end
  end

  assign state       = state_q;
  assign gen_cnt     = gen_q;
  assign population  = pop_q;
  assign halt_reason = reason_q;
  assign eng_step    = eng_step_q;
  assign load_req    = load_req_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Bench for life_gen_sequencer: an engine model answers eng_step, pushes the
// expected generation/population into a scoreboard and compares on update.
module tb_life_gen_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_run, cmd_pause, cmd_step, cmd_load;
  logic [23:0] period;
  logic [31:0] gen_limit;
  logic        eng_step, eng_done;
  logic [8:0]  eng_birth, eng_death;
  logic        load_req, load_ack;
  logic [8:0]  load_pop;
  logic [2:0]  state;
  logic [31:0] gen_cnt;
  logic [8:0]  population;
  logic        halted;
  logic [1:0]  halt_reason;

  typedef struct {
    int gen;
    int pop;
  } exp_t;

  exp_t sb_q[$];
  int   step_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   step_cnt = 0;
  int   m_gen = 0;
  int   m_pop = 0;

  life_gen_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_run(cmd_run), .cmd_pause(cmd_pause), .cmd_step(cmd_step), .cmd_load(cmd_load),
    .period(period), .gen_limit(gen_limit),
    .eng_step(eng_step), .eng_done(eng_done), .eng_birth(eng_birth), .eng_death(eng_death),
    .load_req(load_req), .load_ack(load_ack), .load_pop(load_pop),
    .state(state), .gen_cnt(gen_cnt), .population(population),
    .halted(halted), .halt_reason(halt_reason)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (eng_step) begin
      step_cnt <= step_cnt + 1;
      step_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // mask bits: [3] load, [2] pause, [1] step, [0] run
  task automatic pulse(input logic [3:0] mask);
    @(posedge clk); #1;
    {cmd_load, cmd_pause, cmd_step, cmd_run} = mask;
    @(posedge clk); #1;
    {cmd_load, cmd_pause, cmd_step, cmd_run} = 4'b0000;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target, input int max_cyc);
    int n = 0;
    while (state !== target && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, state, target);
  endtask

  task automatic do_load(input int pop, input logic [3:0] extra);
    pulse(4'b1000 | extra);
    @(negedge clk);
    chk("load_state", state, 3'd4);
    chk("load_req_hi", load_req, 1'b1);
    @(posedge clk); #1;
    load_pop = 9'(pop);
    load_ack = 1'b1;
    @(posedge clk); #1;
    load_ack = 1'b0;
    @(negedge clk);
    chk("load_done_state", state, 3'd0);
    chk("load_req_lo", load_req, 1'b0);
    chk("load_pop", population, 32'(pop));
    chk("load_gen", gen_cnt, 32'd0);
    m_gen = 0;
    m_pop = pop;
  endtask

  // Engine model: answer one eng_step with eng_done three cycles later.
  task automatic serve(input int b, input int d, input bit pause_busy);
    int   n = 0;
    exp_t e;
    while (!eng_step && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("step_seen", eng_step, 1'b1);
    if (!eng_step) return;
    @(posedge clk); #1;
    if (pause_busy) cmd_pause = 1'b1;
    @(posedge clk); #1;
    cmd_pause = 1'b0;
    @(posedge clk); #1;
    eng_done  = 1'b1;
    eng_birth = 9'(b);
    eng_death = 9'(d);
    m_gen = m_gen + 1;
    m_pop = m_pop + b - d;
    if (m_pop < 0)   m_pop = 0;
    if (m_pop > 256) m_pop = 256;
    e.gen = m_gen;
    e.pop = m_pop;
    sb_q.push_back(e);
    @(posedge clk); #1;
    eng_done  = 1'b0;
    eng_birth = '0;
    eng_death = '0;
    @(negedge clk);
    e = sb_q.pop_front();
    chk("sb_gen", gen_cnt, 32'(e.gen));
    chk("sb_pop", population, 32'(e.pop));
  endtask

  initial begin
    int base;
    rst = 1'b1;
    {cmd_load, cmd_pause, cmd_step, cmd_run} = 4'b0000;
    period = 24'd4; gen_limit = '0;
    eng_done = 1'b0; eng_birth = '0; eng_death = '0;
    load_ack = 1'b0; load_pop = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", state, 3'd0);
    chk("rst_step", eng_step, 1'b0);
    chk("rst_load_req", load_req, 1'b0);
    chk("rst_gen", gen_cnt, 32'd0);
    chk("rst_pop", population, 32'd0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_reason", halt_reason, 2'd0);
    rst = 1'b0;

    // free run, period 4, births == deaths
    do_load(5, 4'b0000);
    period = 24'd4;
    base = step_cnt;
    pulse(4'b0001);
    @(negedge clk);
    chk("run_wait", state, 3'd1);
    for (int i = 0; i < 3; i++) serve(1, 1, 1'b0);
    chk("free_wait", state, 3'd1);
    chk("spacing1", 32'(step_cyc[base+1] - step_cyc[base]), 32'd8);
    chk("spacing2", 32'(step_cyc[base+2] - step_cyc[base+1]), 32'd8);
    pulse(4'b0100);
    @(negedge clk);
    chk("pause_wait_idle", state, 3'd0);
    base = step_cnt;
    repeat (15) @(negedge clk);
    chk("paused_no_step", step_cnt, base);

    // single step
    do_load(5, 4'b0000);
    pulse(4'b0010);
    serve(2, 0, 1'b0);
    chk("single_idle", state, 3'd0);
    base = step_cnt;
    repeat (20) @(negedge clk);
    chk("single_no_more", step_cnt, base);

    // engine done outside BUSY is ignored
    @(posedge clk); #1;
    eng_done = 1'b1; eng_birth = 9'd3;
    @(posedge clk); #1;
    eng_done = 1'b0; eng_birth = '0;
    @(negedge clk);
    chk("stray_done_gen", gen_cnt, 32'd1);
    chk("stray_done_pop", population, 32'd7);

    // pause while BUSY
    pulse(4'b0001);
    serve(1, 1, 1'b1);
    chk("pause_busy_idle", state, 3'd0);
    base = step_cnt;
    repeat (15) @(negedge clk);
    chk("pause_busy_no_step", step_cnt, base);

    // generation limit
    do_load(5, 4'b0000);
    gen_limit = 32'd3;
    period = 24'd2;
    pulse(4'b0001);
    for (int i = 0; i < 3; i++) serve(1, 1, 1'b0);
    chk("limit_state", state, 3'd5);
    chk("limit_halted", halted, 1'b1);
    chk("limit_reason", halt_reason, 2'd1);
    base = step_cnt;
    pulse(4'b0011);
    repeat (10) @(negedge clk);
    chk("halt_ignores_run", state, 3'd5);
    chk("halt_no_step", step_cnt, base);
    do_load(5, 4'b0000);
    chk("reload_halted", halted, 1'b0);
    chk("reload_reason", halt_reason, 2'd0);
    gen_limit = '0;

    // extinction, exact and clamped
    do_load(2, 4'b0000);
    pulse(4'b0010);
    serve(0, 2, 1'b0);
    chk("ext_state", state, 3'd5);
    chk("ext_reason", halt_reason, 2'd2);
    do_load(2, 4'b0000);
    pulse(4'b0010);
    serve(0, 5, 1'b0);
    chk("clamp_state", state, 3'd5);
    chk("clamp_reason", halt_reason, 2'd2);

    // period 0 behaves as 1
    do_load(5, 4'b0000);
    period = '0;
    base = step_cnt;
    pulse(4'b0001);
    serve(1, 1, 1'b0);
    serve(1, 1, 1'b1);
    chk("p0_spacing", 32'(step_cyc[base+1] - step_cyc[base]), 32'd5);
    chk("p0_idle", state, 3'd0);
    period = 24'd4;

    // load and run in the same cycle: load wins
    do_load(9, 4'b0001);

    // reset while BUSY
    pulse(4'b0010);
    wait_state("reach_busy", 3'd3, 10);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rb_state", state, 3'd0);
    chk("rb_step", eng_step, 1'b0);
    chk("rb_load_req", load_req, 1'b0);
    chk("rb_gen", gen_cnt, 32'd0);
    chk("rb_pop", population, 32'd0);
    chk("rb_halted", halted, 1'b0);
    chk("rb_reason", halt_reason, 2'd0);
    rst = 1'b0;
    base = step_cnt;
    repeat (10) @(negedge clk);
    chk("rb_no_step", step_cnt, base);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
